// File: rtl/ucsbece154b_bp_ctrl.sv
// Branch-predictor update controller: carries fetch-time prediction metadata through D/E
// and turns the Execute-stage outcome into BTB/PHT/GHR updates, redirects and statistics.
module ucsbece154b_bp_ctrl #(
    parameter int NUM_BTB_ENTRIES = 32,
    parameter int NUM_GHR_BITS    = 5
) (
    input  logic                                 clk,
    input  logic                                 reset_i,
    input  logic                                 StallD_i,
    input  logic                                 FlushD_i,
    input  logic                                 FlushE_i,
    input  logic [31:0]                          PCF_i,
    input  logic                                 BranchTakenF_i,
    input  logic [31:0]                          BTBtargetF_i,
    input  logic [NUM_GHR_BITS-1:0]              PHTreadaddressF_i,
    input  logic                                 BranchE_i,
    input  logic                                 JumpE_i,
    input  logic                                 ActualTakenE_i,
    input  logic [31:0]                          ActualTargetE_i,
    output logic                                 BTB_we_o,
    output logic [$clog2(NUM_BTB_ENTRIES)-1:0]   BTBwriteaddress_o,
    output logic [65:0]                          BTBwritedata_o,
    output logic                                 PHTwe_o,
    output logic                                 PHTincrement_o,
    output logic [NUM_GHR_BITS-1:0]              PHTwriteaddress_o,
    output logic                                 GHRreset_o,
    output logic                                 MispredictE_o,
    output logic [31:0]                          RedirectPCE_o,
    output logic [31:0]                          BranchCount_o,
    output logic [31:0]                          MispredictCount_o
);

    localparam int IDX = $clog2(NUM_BTB_ENTRIES);

    typedef struct packed {
        logic                    valid;
        logic [31:0]             pc;
        logic                    pred_taken;
        logic [31:0]             pred_target;
        logic [NUM_GHR_BITS-1:0] pht_idx;
    } meta_t;

    meta_t       meta_d, meta_e;
    logic [31:0] branch_cnt, mispredict_cnt;

    logic resolve, mispredict, target_miss, is_branch;

    // Flush beats stall; only the valid bit needs clearing for a bubble.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            meta_d.valid <= 1'b0;
        end else if (FlushD_i) begin
            meta_d.valid <= 1'b0;
        end else if (!StallD_i) begin
            meta_d.valid       <= 1'b1;
            meta_d.pc          <= PCF_i;
            meta_d.pred_taken  <= BranchTakenF_i;
            meta_d.pred_target <= BTBtargetF_i;
            meta_d.pht_idx     <= PHTreadaddressF_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i || FlushE_i) begin
            meta_e.valid <= 1'b0;
        end else begin
            meta_e <= meta_d;
        end
    end

    // A jump that is also flagged as a branch is treated purely as a jump.
    assign is_branch   = BranchE_i & ~JumpE_i;
    assign resolve     = meta_e.valid & (BranchE_i | JumpE_i);
    assign target_miss = meta_e.pred_target != ActualTargetE_i;
    assign mispredict  = (meta_e.pred_taken != ActualTakenE_i) | (ActualTakenE_i & target_miss);

    always_comb begin
        BTB_we_o          = 1'b0;
        BTBwriteaddress_o = '0;
        BTBwritedata_o    = '0;
        PHTwe_o           = 1'b0;
        PHTincrement_o    = 1'b0;
        PHTwriteaddress_o = '0;
        GHRreset_o        = 1'b0;
        MispredictE_o     = 1'b0;
        RedirectPCE_o     = '0;
        if (resolve) begin
            BTB_we_o          = ActualTakenE_i & (~meta_e.pred_taken | target_miss);
            BTBwriteaddress_o = meta_e.pc[IDX+1:2];
            BTBwritedata_o    = {is_branch, JumpE_i, 32'(meta_e.pc >> (IDX+2)), ActualTargetE_i};
            PHTwe_o           = is_branch;
            PHTincrement_o    = ActualTakenE_i;
            PHTwriteaddress_o = meta_e.pht_idx;
            GHRreset_o        = mispredict;
            MispredictE_o     = mispredict;
            RedirectPCE_o     = ActualTakenE_i ? ActualTargetE_i : meta_e.pc + 32'd4;
        end
    end

    // Statistics counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            if (resolve && branch_cnt != '1)
                branch_cnt <= branch_cnt + 32'd1;
            if (resolve && mispredict && mispredict_cnt != '1)
                mispredict_cnt <= mispredict_cnt + 32'd1;
        end
    end

    assign BranchCount_o     = branch_cnt;
    assign MispredictCount_o = mispredict_cnt;

endmodule

// File: tb/tb_ucsbece154b_bp_ctrl.sv
// Scoreboard bench for ucsbece154b_bp_ctrl: directed scenarios plus random traffic
// against a spec-level reference model; a negedge monitor checks every cycle.
module tb_ucsbece154b_bp_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_i, StallD_i, FlushD_i, FlushE_i;
    logic [31:0] PCF_i, BTBtargetF_i, ActualTargetE_i;
    logic        BranchTakenF_i, BranchE_i, JumpE_i, ActualTakenE_i;
    logic [4:0]  PHTreadaddressF_i;
    logic        BTB_we_o, PHTwe_o, PHTincrement_o, GHRreset_o, MispredictE_o;
    logic [4:0]  BTBwriteaddress_o, PHTwriteaddress_o;
    logic [65:0] BTBwritedata_o;
    logic [31:0] RedirectPCE_o, BranchCount_o, MispredictCount_o;

    ucsbece154b_bp_ctrl #(.NUM_BTB_ENTRIES(32), .NUM_GHR_BITS(5)) dut (
        .clk(clk), .reset_i(reset_i), .StallD_i(StallD_i), .FlushD_i(FlushD_i), .FlushE_i(FlushE_i),
        .PCF_i(PCF_i), .BranchTakenF_i(BranchTakenF_i), .BTBtargetF_i(BTBtargetF_i),
        .PHTreadaddressF_i(PHTreadaddressF_i), .BranchE_i(BranchE_i), .JumpE_i(JumpE_i),
        .ActualTakenE_i(ActualTakenE_i), .ActualTargetE_i(ActualTargetE_i),
        .BTB_we_o(BTB_we_o), .BTBwriteaddress_o(BTBwriteaddress_o), .BTBwritedata_o(BTBwritedata_o),
        .PHTwe_o(PHTwe_o), .PHTincrement_o(PHTincrement_o), .PHTwriteaddress_o(PHTwriteaddress_o),
        .GHRreset_o(GHRreset_o), .MispredictE_o(MispredictE_o), .RedirectPCE_o(RedirectPCE_o),
        .BranchCount_o(BranchCount_o), .MispredictCount_o(MispredictCount_o)
    );

    typedef struct {
        bit        v;
        bit [31:0] pc;
        bit        pt;
        bit [31:0] ptg;
        bit [4:0]  idx;
    } meta_m;

    typedef struct {
        bit        btb_we;
        bit [4:0]  btb_addr;
        bit [65:0] btb_data;
        bit        pht_we, pht_inc;
        bit [4:0]  pht_addr;
        bit        mis;
        bit [31:0] redirect, bcnt, mcnt;
    } exp_t;

    exp_t      sbq[$];
    int        n_cmp = 0, n_err = 0;
    meta_m     md, me;
    bit [31:0] mb, mm;

    task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    function automatic exp_t predict();
        exp_t x;
        bit res, mis, beff;
        res  = me.v & (BranchE_i | JumpE_i);
        beff = BranchE_i & ~JumpE_i;
        mis  = (me.pt != ActualTakenE_i) | (ActualTakenE_i & (me.ptg != ActualTargetE_i));
        x.btb_we   = res & ActualTakenE_i & (!me.pt | (me.ptg != ActualTargetE_i));
        x.btb_addr = res ? me.pc[6:2] : 5'd0;
        x.btb_data = res ? {beff, JumpE_i, me.pc >> 7, ActualTargetE_i} : 66'd0;
        x.pht_we   = res & beff;
        x.pht_inc  = res & ActualTakenE_i;
        x.pht_addr = res ? me.idx : 5'd0;
        x.mis      = res & mis;
        x.redirect = ActualTakenE_i ? ActualTargetE_i : me.pc + 32'd4;
        x.bcnt     = mb;
        x.mcnt     = mm;
        return x;
    endfunction

    task automatic advance();
        bit res, mis;
        res = me.v & (BranchE_i | JumpE_i);
        mis = (me.pt != ActualTakenE_i) | (ActualTakenE_i & (me.ptg != ActualTargetE_i));
        if (reset_i) begin
            mb = 0; mm = 0; me.v = 0; md.v = 0;
        end else begin
            if (res && mb != 32'hFFFFFFFF) mb++;
            if (res && mis && mm != 32'hFFFFFFFF) mm++;
            if (FlushE_i) me.v = 0; else me = md;
            if (FlushD_i) md.v = 0;
            else if (!StallD_i) md = '{1'b1, PCF_i, BranchTakenF_i, BTBtargetF_i, PHTreadaddressF_i};
        end
    endtask

    task automatic step();
        sbq.push_back(predict());
        @(posedge clk);
        advance();
        #1;
    endtask

    task automatic drive(input bit [31:0] pc, input bit pt, input bit [31:0] ptg, input bit [4:0] idx,
                         input bit b, input bit j, input bit at, input bit [31:0] tgt,
                         input bit st, input bit fd, input bit fe);
        PCF_i = pc; BranchTakenF_i = pt; BTBtargetF_i = ptg; PHTreadaddressF_i = idx;
        BranchE_i = b; JumpE_i = j; ActualTakenE_i = at; ActualTargetE_i = tgt;
        StallD_i = st; FlushD_i = fd; FlushE_i = fe;
        step();
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t x;
            x = sbq.pop_front();
            chk("btb_we", 66'(BTB_we_o), 66'(x.btb_we));
            chk("btb_addr", 66'(BTBwriteaddress_o), 66'(x.btb_addr));
            chk("btb_data", BTBwritedata_o, x.btb_data);
            chk("pht_we", 66'(PHTwe_o), 66'(x.pht_we));
            chk("pht_inc", 66'(PHTincrement_o), 66'(x.pht_inc));
            chk("pht_addr", 66'(PHTwriteaddress_o), 66'(x.pht_addr));
            chk("mispredict", 66'(MispredictE_o), 66'(x.mis));
            chk("ghr_reset", 66'(GHRreset_o), 66'(x.mis));
            if (x.mis) chk("redirect", 66'(RedirectPCE_o), 66'(x.redirect));
            chk("branch_count", 66'(BranchCount_o), 66'(x.bcnt));
            chk("mispredict_count", 66'(MispredictCount_o), 66'(x.mcnt));
        end
    end

    initial begin
        reset_i = 1'b1;
        StallD_i = 0; FlushD_i = 0; FlushE_i = 0;
        PCF_i = 0; BranchTakenF_i = 0; BTBtargetF_i = 0; PHTreadaddressF_i = 0;
        BranchE_i = 0; JumpE_i = 0; ActualTakenE_i = 0; ActualTargetE_i = 0;
        md = '{0, 0, 0, 0, 0}; me = md; mb = 0; mm = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_i = 1'b0;

        repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // correct branch, NT->T miss, jal wrong target, predicted-taken resolves not taken
        drive(32'h100, 1, 32'h80,  5, 0, 0, 0, 0,        0, 0, 0);
        drive(32'h104, 0, 32'h0,   3, 0, 0, 0, 0,        0, 0, 0);
        drive(32'h200, 1, 32'h300, 0, 1, 0, 1, 32'h80,   0, 0, 0);
        drive(32'h10,  1, 32'h50,  7, 1, 0, 1, 32'h40,   0, 0, 0);
        drive(32'h20,  0, 32'h0,   1, 0, 1, 1, 32'h400,  0, 0, 0);
        drive(32'h30,  0, 32'h0,   2, 1, 0, 0, 32'h999,  0, 0, 0);
        chk("directed_branch_count", 66'(BranchCount_o), 66'd4);
        chk("directed_mispredict_count", 66'(MispredictCount_o), 66'd3);

        // stall holds D; flush+stall makes an E bubble
        drive(32'h500, 1, 32'hC0,  9, 0, 0, 0, 0,        0, 0, 0);
        drive(32'h600, 0, 32'h0,   1, 0, 0, 0, 0,        1, 0, 0);
        drive(32'h700, 0, 32'h0,   2, 1, 0, 1, 32'hC0,   1, 0, 0);
        drive(32'h740, 0, 32'h0,   3, 1, 0, 1, 32'hC4,   0, 0, 0);
        drive(32'h800, 1, 32'h10,  4, 1, 0, 0, 32'h0,    1, 1, 0);
        drive(32'h900, 1, 32'h10,  4, 0, 1, 1, 32'h10,   0, 0, 0);
        drive(32'h904, 1, 32'h10,  4, 1, 0, 1, 32'h10,   0, 0, 1);
        drive(32'h908, 1, 32'h10,  4, 1, 0, 1, 32'h10,   0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            bit [31:0] tg[4];
            bit        b, j;
            tg[0] = 32'h40; tg[1] = 32'h80; tg[2] = 32'hC0; tg[3] = 32'h1000;
            j = ($urandom_range(0, 3) == 0);
            b = !j && ($urandom_range(0, 2) != 0);
            reset_i = ($urandom_range(0, 59) == 0);
            drive($urandom & 32'hFFFF_FFFC, 1'($urandom), tg[$urandom_range(0, 3)], 5'($urandom),
                  b, j, j | 1'($urandom), tg[$urandom_range(0, 3)],
                  $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
        end
        reset_i = 1'b0;

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        force dut.branch_cnt = 32'hFFFFFFFE;
        #1;
        release dut.branch_cnt;
        mb = 32'hFFFFFFFE;
        drive(32'h40, 0, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(32'h44, 0, 32'h0, 2, 0, 0, 0, 0, 0, 0, 0);
        drive(32'h48, 0, 32'h0, 3, 1, 0, 0, 0, 0, 0, 0);
        drive(32'h4C, 0, 32'h0, 3, 1, 0, 0, 0, 0, 0, 0);
        chk("saturated_branch_count", 66'(BranchCount_o), 66'hFFFFFFFF);
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("saturated_hold", 66'(BranchCount_o), 66'hFFFFFFFF);

        for (int k = 0; k < 5 && sbq.size() > 0; k++) @(posedge clk);
        if (sbq.size() > 0) begin
            n_cmp++; n_err++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
